// File: rtl/lcd_draw_scheduler.sv
// lcd_draw_scheduler: round-robin arbiter that streams clipped rectangles as LCD pixel writes
module lcd_draw_scheduler #(
    parameter int NREQ  = 3,
    parameter int SCR_W = 320,
    parameter int SCR_H = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*9-1:0] rect_x,
    input  logic [NREQ*8-1:0] rect_y,
    input  logic [NREQ*9-1:0] rect_w,
    input  logic [NREQ*8-1:0] rect_h,
    input  logic [NREQ*16-1:0] rect_color,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              pix_valid,
    output logic [8:0]        pix_x,
    output logic [7:0]        pix_y,
    output logic [15:0]       pix_color,
    input  logic              pix_ready,
    output logic              busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

    state_t          state_q;
    logic [IW-1:0]   rr_q, idx_q, win_d;
    logic            any_d;
    logic [NREQ-1:0] grant_q, done_q;
    logic            pv_q;
    logic [8:0]      px_q, x0_q, xl_q, xl_d, x_sel, w_sel;
    logic [7:0]      py_q, yl_q, yl_d, y_sel, h_sel;
    logic [15:0]     pc_q, c_sel;
    logic [9:0]      room_x, w_eff;
    logic [8:0]      room_y, h_eff;
    logic            degen_d;

    // Round-robin pick: the lowest offset after rr_q with a pending request wins
    always_comb begin
        any_d = 1'b0;
        win_d = rr_q;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(rr_q) + i) % NREQ]) begin
                any_d = 1'b1;
                win_d = IW'((int'(rr_q) + i) % NREQ);
            end
        end
    end

    // Select the granted rectangle and clip it against the screen edges
    always_comb begin
        x_sel   = rect_x[int'(idx_q)*9 +: 9];
        y_sel   = rect_y[int'(idx_q)*8 +: 8];
        w_sel   = rect_w[int'(idx_q)*9 +: 9];
        h_sel   = rect_h[int'(idx_q)*8 +: 8];
        c_sel   = rect_color[int'(idx_q)*16 +: 16];
        room_x  = 10'(SCR_W) - {1'b0, x_sel};
        room_y  = 9'(SCR_H) - {1'b0, y_sel};
        w_eff   = ({1'b0, w_sel} < room_x) ? {1'b0, w_sel} : room_x;
        h_eff   = ({1'b0, h_sel} < room_y) ? {1'b0, h_sel} : room_y;
        xl_d    = 9'({1'b0, x_sel} + w_eff - 10'd1);
        yl_d    = 8'({1'b0, y_sel} + h_eff - 9'd1);
        degen_d = (w_sel == 9'd0) || (h_sel == 8'd0) ||
                  ({1'b0, x_sel} >= 10'(SCR_W)) || ({1'b0, y_sel} >= 9'(SCR_H));
    end

    // Scheduler FSM with registered grant, done and pixel outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= IW'(NREQ - 1);
            idx_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            pv_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            pc_q    <= '0;
            x0_q    <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: if (any_d) begin
                    idx_q   <= win_d;
                    grant_q <= NREQ'(1) << win_d;
                    state_q <= LOAD;
                end
                LOAD: begin
                    x0_q <= x_sel;
                    xl_q <= xl_d;
                    yl_q <= yl_d;
                    px_q <= x_sel;
                    py_q <= y_sel;
                    pc_q <= c_sel;
                    if (degen_d) begin
                        done_q  <= grant_q;
                        state_q <= FINISH;
                    end else begin
                        pv_q    <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: if (pix_ready) begin
                    if (px_q == xl_q) begin
                        px_q <= x0_q;
                        if (py_q == yl_q) begin
                            pv_q    <= 1'b0;
                            done_q  <= grant_q;
                            state_q <= FINISH;
                        end else begin
                            py_q <= py_q + 8'd1;
                        end
                    end else begin
                        px_q <= px_q + 9'd1;
                    end
                end
                FINISH: begin
                    rr_q    <= idx_q;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign pix_valid = pv_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign pix_color = pc_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/lcd_draw_scheduler.md
Name: lcd_draw_scheduler

Overview:
- Shares the single LCD pixel-write port between rectangle-drawing requesters: floor, dino sprite and cactus generators.
- Each requester presents a rectangle (origin, width, height, colour).
- The scheduler grants one requester at a time, round-robin. It then streams the clipped rectangle as a raster of pixel writes with a valid/ready handshake to the LCD interface (320x240 screen).

Parameters:
- NREQ, 3, number of requesters (index 0 = floor, 1 = dino, 2 = cactus).
- SCR_W, 320, screen width in pixels.
- SCR_H, 240, screen height in pixels.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester draw request (level).
- rect_x  input  NREQ*9  flattened origin x; requester k at bits [9k+8:9k].
- rect_y  input  NREQ*8  flattened origin y; requester k at [8k+7:8k].
- rect_w  input  NREQ*9  flattened width in pixels.
- rect_h  input  NREQ*8  flattened height in pixels.
- rect_color  input  NREQ*16  flattened RGB565 colour.
- grant  output  NREQ  one-hot; requester currently being served.
- done  output  NREQ  one-cycle pulse when that requester's rectangle is finished.
- pix_valid  output  1  pixel write valid.
- pix_x  output  9  pixel x coordinate.
- pix_y  output  8  pixel y coordinate.
- pix_color  output  16  pixel colour.
- pix_ready  input  1  LCD interface accepts the pixel this cycle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - grant=0, done=0, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0.
  - FSM=IDLE, rr_ptr=NREQ-1, so requester 0 wins first.
  - Reset mid-stream abandons the rectangle; no done pulse is issued.
- FSM states: IDLE, LOAD, STREAM, FINISH.
- IDLE:
  - If any req bit is set, pick the first set index scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Assert grant for the winner; go to LOAD.
  - With no req, stay in IDLE.
- LOAD (1 cycle): latch the winner's x0, y0 and colour.
- Clipping, computed in LOAD:
  - w_eff = min(w, SCR_W-x0); h_eff = min(h, SCR_H-y0), using widths wide enough to avoid overflow.
  - If w==0, h==0, x0>=SCR_W or y0>=SCR_H, go directly to FINISH with no pixels emitted.
  - Otherwise clear counters cx=0, cy=0 and go to STREAM.
- STREAM:
  - pix_valid=1, pix_x=x0+cx, pix_y=y0+cy, pix_color=latched colour.
  - On pix_valid&&pix_ready: cx increments.
  - When cx==w_eff-1, cx wraps to 0 and cy increments.
  - On the accepted pixel with cx==w_eff-1 and cy==h_eff-1, go to FINISH.
  - If pix_ready is low, all pixel outputs hold stable and pix_valid stays high.
- FINISH (1 cycle):
  - done[k]=1 for one cycle; pix_valid=0.
  - rr_ptr=k; grant drops to 0 on entry to IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle N: grant at N+1, first pix_valid at N+2.
  - With pix_ready tied high, one pixel per cycle.
  - A w x h rectangle occupies 2+w*h+1 cycles from IDLE exit back to IDLE.
- Requester contract:
  - Hold rect_* stable from req until done.
  - Deasserting req after grant is ignored; the rectangle completes.
  - Changing rect_* after LOAD has no effect.
- Simultaneous requests:
  - Only one grant at a time.
  - Back-to-back service: a requester still asserting req after its own done is served again only after the other pending requesters (round-robin fairness).
- Invariants:
  - grant is one-hot or zero.
  - done is asserted only for the index whose grant is set in the same cycle.
  - pix_valid is high only in STREAM.

Test Plan:
- Single request:
  - Stimulus: req=001, floor rect x0=0, y0=100, w=4, h=2, colour 0x07E0, pix_ready=1.
  - Required: grant=001 one cycle after req; 8 pixels in order (0,100)(1,100)(2,100)(3,100)(0,101)...(3,101), all colour 0x07E0; done[0] pulse; busy low after.
- Round-robin:
  - Stimulus: req=111 held, every rect 1x1.
  - Required: grant order 001, 010, 100, 001, ...; exactly one done pulse per grant.
- Backpressure:
  - Stimulus: 2x1 rectangle; pix_ready=0 for 3 cycles during the first pixel.
  - Required: pix_x/pix_y/pix_color held constant with pix_valid=1; exactly 2 accepted pixels.
- Clipping:
  - Stimulus: x0=318, y0=238, w=5, h=5.
  - Required: only 4 pixels, (318,238)(319,238)(318,239)(319,239), then done.
- Degenerate rectangles:
  - Stimulus: w=0, and separately x0=320.
  - Required: no pix_valid; done pulse 3 cycles after req.
- Reset mid-operation:
  - Stimulus: assert reset during STREAM of a 10x10 rectangle.
  - Required: all outputs 0 immediately; no done pulse. After release with req=011, requester 0 is granted first.
